ptch_integrator: RTL and testbench

- Upstream stage of the PID block. Converts raw inertial samples (pitch rate, Z-axis acceleration) into the `ptch`, `ptch_rt` and `vld` signals the PID consumes.
- Calibrates the gyro offset, then integrates the offset-compensated rate into a pitch angle.
- Accelerometer fusion (optional) removes long-term drift.
- Sits between the inertial SPI interface and PID.

---
 rtl/ptch_integrator_pkg.sv | 19 +
 rtl/ptch_offset_cal.sv | 45 ++++
 rtl/ptch_integrator.sv | 135 +++++++++++++
 tb/tb_ptch_integrator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ptch_integrator_pkg.sv
// Shared types, constants and the 16-bit saturation helper for the pitch integrator.
package ptch_integrator_pkg;

    typedef enum logic {CAL, RUN} ptch_state_t;

    localparam int INT_W     = 27;
    localparam int ACC_GAIN  = 327;
    localparam int ACC_SHIFT = 13;
    localparam int PTCH_LSB  = 11;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
        if (x > 17'sd32767)
            return 16'sh7FFF;
        else if (x < -17'sd32768)
            return 16'sh8000;
        return x[15:0];
    endfunction

endpackage

// File: rtl/ptch_offset_cal.sv
// Gyro offset calibration: averages 2^CAL_L raw rate samples into a signed offset.
module ptch_offset_cal
    import ptch_integrator_pkg::*;
#(
    parameter int CAL_L = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               smp,
    input  logic signed [15:0] raw,
    output logic signed [15:0] offset,
    output logic               done
);

    logic        [CAL_L-1:0]  cnt;
    logic signed [15+CAL_L:0] sum;
    logic signed [15+CAL_L:0] sum_nxt;
    logic signed [15+CAL_L:0] avg;

    assign sum_nxt = sum + (16 + CAL_L)'(raw);
    assign avg     = sum_nxt >>> CAL_L;
    // done marks the sample that completes the window; clr wins over it
    assign done    = smp && !clr && (cnt == {CAL_L{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sum    <= '0;
            offset <= '0;
        end else if (clr) begin
            cnt <= '0;
            sum <= '0;
        end else if (smp) begin
            cnt <= cnt + CAL_L'(1);
            if (cnt == {CAL_L{1'b1}}) begin
                sum    <= '0;
                offset <= avg[15:0];
            end else begin
                sum <= sum_nxt;
            end
        end
    end

endmodule

// File: rtl/ptch_integrator.sv
// Pitch integrator: offset-calibrated gyro integration into ptch, with optional
// accelerometer drift correction enabled by defining PTCH_ACCEL_FUSION_EN.
module ptch_integrator
    import ptch_integrator_pkg::*;
#(
    parameter bit                 fast_sim    = 1'b1,
    parameter int                 CAL_LOG2    = 8,
    parameter int                 FUSION_STEP = 1024,
    parameter logic signed [15:0] AZ_OFFSET   = 16'sh00A0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld_in,
    input  logic signed [15:0] ptch_rt_raw,
    input  logic signed [15:0] AZ,
    input  logic               cal_req,
    output logic signed [15:0] ptch,
    output logic signed [15:0] ptch_rt,
    output logic               vld,
    output logic               cal_done
);

    localparam int CAL_L = fast_sim ? 4 : CAL_LOG2;
    localparam logic signed [INT_W:0] INT_MAX = (INT_W + 1)'((64'sd1 <<< (INT_W - 1)) - 64'sd1);
    localparam logic signed [INT_W:0] INT_MIN = -INT_MAX - (INT_W + 1)'(1);

    function automatic logic signed [INT_W-1:0] sat_int(input logic signed [INT_W:0] x);
        if (x > INT_MAX)
            return INT_MAX[INT_W-1:0];
        else if (x < INT_MIN)
            return INT_MIN[INT_W-1:0];
        return x[INT_W-1:0];
    endfunction

    ptch_state_t              state;
    logic signed [15:0]       offset;
    logic                     cal_fin;
    logic signed [16:0]       rt_diff_p0;
    logic                     vld_p1;
    logic signed [15:0]       rt_comp_p1;
    logic signed [INT_W:0]    corr_p1;
    logic signed [INT_W:0]    int_sum_p1;
    logic signed [INT_W-1:0]  integ_p2;

    ptch_offset_cal #(.CAL_L(CAL_L)) u_cal (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cal_req),
        .smp    (vld_in && (state == CAL)),
        .raw    (ptch_rt_raw),
        .offset (offset),
        .done   (cal_fin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CAL;
            cal_done <= 1'b0;
        end else if (cal_req) begin
            state    <= CAL;
            cal_done <= 1'b0;
        end else if (state == CAL && cal_fin) begin
            state    <= RUN;
            cal_done <= 1'b1;
        end
    end

    // Stage 1: offset compensation (and accel angle estimate)
    assign rt_diff_p0 = 17'(ptch_rt_raw) - 17'(offset);

`ifdef PTCH_ACCEL_FUSION_EN
    localparam logic signed [26:0]    GAIN     = 27'(ACC_GAIN);
    localparam logic signed [INT_W:0] STEP_POS = (INT_W + 1)'(FUSION_STEP);

    logic signed [26:0] az_diff_p0;
    logic signed [26:0] az_prod_p0;
    logic signed [15:0] acc_ptch_p1;

    assign az_diff_p0 = 27'(AZ) - 27'(AZ_OFFSET);
    assign az_prod_p0 = az_diff_p0 * GAIN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_ptch_p1 <= '0;
        else if (vld_in && state == RUN)
            acc_ptch_p1 <= 16'(az_prod_p0 >>> ACC_SHIFT);
    end

    always_comb begin
        corr_p1 = '0;
        if (acc_ptch_p1 > ptch)
            corr_p1 = STEP_POS;
        else if (acc_ptch_p1 < ptch)
            corr_p1 = -STEP_POS;
    end
`else
    logic unused_accel;

    assign unused_accel = ^{AZ, AZ_OFFSET, 32'(FUSION_STEP)};
    assign corr_p1      = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            rt_comp_p1 <= '0;
        end else begin
            vld_p1 <= vld_in && (state == RUN) && !cal_req;
            if (vld_in && state == RUN)
                rt_comp_p1 <= sat16(rt_diff_p0);
        end
    end

    // Stage 2: integrate at one extra bit, then clamp to the 27-bit range
    assign int_sum_p1 = (INT_W + 1)'(integ_p2) - (INT_W + 1)'(rt_comp_p1) + corr_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_p2 <= '0;
            ptch_rt  <= '0;
            vld      <= 1'b0;
        end else begin
            vld <= vld_p1 && !cal_req;
            if (cal_req) begin
                integ_p2 <= '0;
            end else if (vld_p1) begin
                integ_p2 <= sat_int(int_sum_p1);
                ptch_rt  <= rt_comp_p1;
            end
        end
    end

    assign ptch = integ_p2[PTCH_LSB +: 16];

endmodule

// File: tb/tb_ptch_integrator.sv
// Scoreboard bench for ptch_integrator: a plain-arithmetic model predicts every vld result.
module tb_ptch_integrator;

    localparam int AZ_OFF = 160;
    localparam int FSTEP  = 1024;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               vld_in = 1'b0;
    logic signed [15:0] ptch_rt_raw = '0;
    logic signed [15:0] AZ = '0;
    logic               cal_req = 1'b0;
    logic signed [15:0] ptch;
    logic signed [15:0] ptch_rt;
    logic               vld;
    logic               cal_done;

    ptch_integrator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld_in      (vld_in),
        .ptch_rt_raw (ptch_rt_raw),
        .AZ          (AZ),
        .cal_req     (cal_req),
        .ptch        (ptch),
        .ptch_rt     (ptch_rt),
        .vld         (vld),
        .cal_done    (cal_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint rt;
        longint p;
        int     due;
    } exp_t;

    exp_t   expq[$];
    int     n_chk = 0;
    int     n_fail = 0;

    bit     m_cal = 1'b1;
    int     m_cnt = 0;
    longint m_sum = 0;
    longint m_off = 0;
    longint m_int = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint clamp(input longint x, input longint lo, input longint hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic longint m_ptch();
        return m_int >>> 11;
    endfunction

    function automatic void model_reset();
        m_cal = 1'b1;
        m_cnt = 0;
        m_sum = 0;
        m_int = 0;
    endfunction

    // One clock of stimulus; the model is advanced with the same sample
    task automatic drive(input bit v, input int r, input int a, input bit c);
        longint rt, corr;
        logic signed [15:0] acc16;
        vld_in      = v;
        ptch_rt_raw = 16'(r);
        AZ          = 16'(a);
        cal_req     = c;
        if (c) begin
            if (expq.size() > 0 && expq[$].due == cyc + 1)
                void'(expq.pop_back());
            model_reset();
        end else if (v) begin
            if (m_cal) begin
                m_sum += r;
                m_cnt++;
                if (m_cnt == 16) begin
                    m_off = m_sum >>> 4;
                    m_cal = 1'b0;
                    m_cnt = 0;
                end
            end else begin
                rt   = clamp(r - m_off, -32768, 32767);
                corr = 0;
                acc16 = 16'((longint'(a - AZ_OFF) * 327) >>> 13);
`ifdef PTCH_ACCEL_FUSION_EN
                if (acc16 > m_ptch()) corr = FSTEP;
                else if (acc16 < m_ptch()) corr = -FSTEP;
`endif
                m_int = clamp(m_int - rt + corr, -(64'sd1 <<< 26), (64'sd1 <<< 26) - 1);
                expq.push_back('{rt, m_ptch(), cyc + 2});
            end
        end
        @(posedge clk);
        #1;
        vld_in  = 1'b0;
        cal_req = 1'b0;
        check("cal_done", cal_done, !m_cal);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, AZ_OFF, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && vld) begin
                if (expq.size() == 0) begin
                    check("unexpected_vld", vld, 0);
                end else begin
                    e = expq.pop_front();
                    check("ptch_rt", ptch_rt, e.rt);
                    check("ptch", ptch, e.p);
                    check("vld_latency", cyc, e.due);
                end
            end else if (rst_n && expq.size() > 0 && expq[0].due <= cyc) begin
                check("missing_vld", vld, 1);
                void'(expq.pop_front());
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        #1;
        check("rst_ptch", ptch, 0);
        check("rst_ptch_rt", ptch_rt, 0);
        check("rst_vld", vld, 0);
        check("rst_cal_done", cal_done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(100);

        // Calibrate to offset 100, then flat samples
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 100, AZ_OFF, 1'b0);
            check("cal_ptch_hold", ptch, 0);
        end
        for (int i = 0; i < 10; i++) drive(1'b1, 100, AZ_OFF, 1'b0);
        idle(3);

        for (int i = 0; i < 1024; i++) drive(1'b1, 2148, AZ_OFF, 1'b0);
        idle(3);
`ifndef PTCH_ACCEL_FUSION_EN
        check("pure_int_ptch", ptch, -1024);
`endif

        // Restart calibration from RUN together with a sample, then again mid-CAL
        idle(1);
        drive(1'b1, 500, AZ_OFF, 1'b1);
        check("calreq_ptch_zero", ptch, 0);
        for (int i = 0; i < 5; i++) drive(1'b1, -100, AZ_OFF, 1'b0);
        drive(1'b0, 0, AZ_OFF, 1'b1);
        for (int i = 0; i < 16; i++) drive(1'b1, -100, AZ_OFF, 1'b0);
        for (int i = 0; i < 2100; i++) drive(1'b1, 32767, AZ_OFF, 1'b0);
        idle(3);
`ifndef PTCH_ACCEL_FUSION_EN
        check("sat_neg_ptch", ptch, -32768);
`endif

        drive(1'b0, 0, AZ_OFF, 1'b1);
        for (int i = 0; i < 16; i++) drive(1'b1, 100, AZ_OFF, 1'b0);
        for (int i = 0; i < 2100; i++) drive(1'b1, -32768, AZ_OFF, 1'b0);
        idle(3);
`ifndef PTCH_ACCEL_FUSION_EN
        check("sat_pos_ptch", ptch, 32767);
`endif

        // Accel-driven run with zero compensated rate
        for (int i = 0; i < 700; i++) drive(1'b1, 100, AZ_OFF + 8192, 1'b0);
        idle(3);

        // Randomized traffic with sparse gaps and occasional recalibration
        drive(1'b0, 0, AZ_OFF, 1'b1);
        for (int i = 0; i < 16; i++) drive(1'b1, int'($urandom_range(4000)) - 2000, AZ_OFF, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            int r, a;
            r = int'($urandom_range(65535)) - 32768;
            a = int'($urandom_range(65535)) - 32768;
            if ($urandom_range(99) == 0)
                drive($urandom_range(1) == 1, r, a, 1'b1);
            else
                drive($urandom_range(4) != 0, r, a, 1'b0);
        end
        idle(3);

        // Asynchronous reset mid-stream with samples in flight
        for (int i = 0; i < 20; i++) drive(1'b1, 1234, AZ_OFF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ptch", ptch, 0);
        check("arst_ptch_rt", ptch_rt, 0);
        check("arst_vld", vld, 0);
        check("arst_cal_done", cal_done, 0);
        model_reset();
        m_off = 0;
        expq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 37, AZ_OFF, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, int'($urandom_range(2000)), AZ_OFF, 1'b0);
        idle(5);

        check("queue_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
